fp16ftz_decoder: RTL and testbench

- Converts a packed IEEE-754 binary16 word into the unpacked {sign, exponent, mantissa, type} form consumed by the fp16 arithmetic units. It is the inverse of the FTZ encoder.
- Flush-to-zero policy: subnormal inputs are delivered as signed zero and counted.
- Streaming block with a valid/ready handshake on both sides, a registered decode stage and a 2-entry skid buffer, so that o_ready is a flop output.

---
 rtl/fp16ftz_decoder.sv | 205 ++++++++++++++++++++
 tb/tb_fp16ftz_decoder.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fp16ftz_decoder.sv
// fp16ftz_decoder
//   Unpacks an IEEE-754 binary16 word into {sign, biased exponent,
//   significand with hidden bit, type} for the fp16 arithmetic units.
//   Subnormal inputs are flushed to signed zero and counted.
//   The block is streaming: valid/ready on both sides, one registered
//   decode stage (OUT) and one skid register (SKID). o_ready is a flop.
//
//   Optional feature macro: FP16_DECODER_SUBN_EN
//     defined   : subnormals pass through as SUBN (exp 1, mant {0,f}),
//                 o_ftz_count stays 0
//     undefined : flush-to-zero with counting
//
// Ports
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_valid/o_ready/i_data  upstream handshake and packed word
//   o_valid/i_ready         downstream handshake
//   o_sign/o_exponent/o_mantissa/o_type   decoded fields
//   o_ftz_count, i_cnt_clear              saturating flush counter, clear
//
// state   | meaning
// S_EMPTY | no word held, o_valid=0
// S_ONE   | OUT holds a word
// S_TWO   | OUT and SKID hold words, o_ready=0

`ifndef FP16_WIDTH
`define FP16_WIDTH 16
`endif
`ifndef FP16_EXPONENT_WIDTH
`define FP16_EXPONENT_WIDTH 5
`endif
`ifndef FP16_MANTISSA_WIDTH
`define FP16_MANTISSA_WIDTH 11
`endif
`ifndef FP16_TYPE_WIDTH
`define FP16_TYPE_WIDTH 3
`endif
`ifndef FP16_ZERO
`define FP16_ZERO 3'd0
`endif
`ifndef FP16_SUBN
`define FP16_SUBN 3'd1
`endif
`ifndef FP16_NORM
`define FP16_NORM 3'd2
`endif
`ifndef FP16_INF
`define FP16_INF 3'd3
`endif
`ifndef FP16_NAN
`define FP16_NAN 3'd4
`endif

module fp16ftz_decoder #(
   parameter int CNT_WIDTH = 16
) (
   input  logic                            i_clk,
   input  logic                            i_rst,
   input  logic                            i_valid,
   output logic                            o_ready,
   input  logic [`FP16_WIDTH-1:0]          i_data,
   output logic                            o_valid,
   input  logic                            i_ready,
   output logic                            o_sign,
   output logic [`FP16_EXPONENT_WIDTH-1:0] o_exponent,
   output logic [`FP16_MANTISSA_WIDTH-1:0] o_mantissa,
   output logic [`FP16_TYPE_WIDTH-1:0]     o_type,
   output logic [CNT_WIDTH-1:0]            o_ftz_count,
   input  logic                            i_cnt_clear
);

   localparam int EW = `FP16_EXPONENT_WIDTH;
   localparam int MW = `FP16_MANTISSA_WIDTH;
   localparam int TW = `FP16_TYPE_WIDTH;
   localparam int DW = 1 + EW + MW + TW;

`ifdef FP16_DECODER_SUBN_EN
   localparam bit FTZ_EN = 1'b0;
`else
   localparam bit FTZ_EN = 1'b1;
`endif

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_TWO   = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic                valid_q, valid_d;
   logic                ready_q, ready_d;
   logic [DW-1:0]       out_q, out_d;
   logic [DW-1:0]       skid_q, skid_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

   logic                in_sign;
   logic [4:0]          in_exp;
   logic [9:0]          in_frac;
   logic                is_subn;
   logic [EW-1:0]       dec_exp;
   logic [MW-1:0]       dec_mant;
   logic [TW-1:0]       dec_type;
   logic [DW-1:0]       dec_word;
   logic                in_xfer;
   logic                out_xfer;

   assign in_sign  = i_data[15];
   assign in_exp   = i_data[14:10];
   assign in_frac  = i_data[9:0];
   assign is_subn  = (in_exp == 5'd0) && (in_frac != 10'd0);
   assign in_xfer  = i_valid & ready_q;
   assign out_xfer = valid_q & i_ready;

   always_comb begin
      dec_exp  = '0;
      dec_mant = '0;
      dec_type = `FP16_ZERO;
      if (in_exp == 5'd31) begin
         dec_exp  = in_exp;
         dec_mant = {1'b0, in_frac};
         dec_type = (in_frac == 10'd0) ? `FP16_INF : `FP16_NAN;
      end else if (in_exp != 5'd0) begin
         dec_exp  = in_exp;
         dec_mant = {1'b1, in_frac};
         dec_type = `FP16_NORM;
      end else if (is_subn && !FTZ_EN) begin
         // Subnormal exponent is reported as 1 so exp/mant keep their value meaning
         dec_exp  = 5'd1;
         dec_mant = {1'b0, in_frac};
         dec_type = `FP16_SUBN;
      end
   end

   assign dec_word = {in_sign, dec_exp, dec_mant, dec_type};

   always_comb begin
      state_d = state_q;
      out_d   = out_q;
      skid_d  = skid_q;
      unique case (state_q)
         S_EMPTY: begin
            if (in_xfer) begin
               out_d   = dec_word;
               state_d = S_ONE;
            end
         end
         S_ONE: begin
            case ({in_xfer, out_xfer})
               2'b11: out_d = dec_word;
               2'b01: state_d = S_EMPTY;
               2'b10: begin
                  skid_d  = dec_word;
                  state_d = S_TWO;
               end
               default: ;
            endcase
         end
         S_TWO: begin
            // o_ready is low here, so only a drain can happen
            if (out_xfer) begin
               out_d   = skid_q;
               state_d = S_ONE;
            end
         end
         default: state_d = S_EMPTY;
      endcase
      valid_d = (state_d != S_EMPTY);
      ready_d = (state_d != S_TWO);
   end

   always_comb begin
      cnt_d = cnt_q;
      if (i_cnt_clear) begin
         cnt_d = '0;
      end else if (FTZ_EN && in_xfer && is_subn && (cnt_q != {CNT_WIDTH{1'b1}})) begin
         cnt_d = cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= S_EMPTY;
         valid_q <= 1'b0;
         ready_q <= 1'b1;
         out_q   <= '0;
         skid_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         valid_q <= valid_d;
         ready_q <= ready_d;
         out_q   <= out_d;
         skid_q  <= skid_d;
         cnt_q   <= cnt_d;
      end
   end

   assign o_valid     = valid_q;
   assign o_ready     = ready_q;
   assign o_sign      = out_q[DW-1];
   assign o_exponent  = out_q[DW-2 -: EW];
   assign o_mantissa  = out_q[TW +: MW];
   assign o_type      = out_q[TW-1:0];
   assign o_ftz_count = cnt_q;

endmodule

// File: tb/tb_fp16ftz_decoder.sv
// Self-checking bench for fp16ftz_decoder: directed scenarios followed by a
// randomized phase, all checked against a queue-based reference model.

`ifndef FP16_ZERO
`define FP16_ZERO 3'd0
`endif
`ifndef FP16_SUBN
`define FP16_SUBN 3'd1
`endif
`ifndef FP16_NORM
`define FP16_NORM 3'd2
`endif
`ifndef FP16_INF
`define FP16_INF 3'd3
`endif
`ifndef FP16_NAN
`define FP16_NAN 3'd4
`endif

module tb_fp16ftz_decoder;

   localparam int CW = 8;
   localparam int CMAX = (1 << CW) - 1;
`ifdef FP16_DECODER_SUBN_EN
   localparam bit FTZ = 1'b0;
`else
   localparam bit FTZ = 1'b1;
`endif

   typedef struct {
      logic        s;
      logic [4:0]  e;
      logic [10:0] m;
      logic [2:0]  t;
   } dec_t;

   logic          i_clk = 1'b0;
   logic          i_rst;
   logic          i_valid;
   logic          o_ready;
   logic [15:0]   i_data;
   logic          o_valid;
   logic          i_ready;
   logic          o_sign;
   logic [4:0]    o_exponent;
   logic [10:0]   o_mantissa;
   logic [2:0]    o_type;
   logic [CW-1:0] o_ftz_count;
   logic          i_cnt_clear;

   int   n_cmp  = 0;
   int   n_fail = 0;
   dec_t q[$];
   int   cnt_m  = 0;

   fp16ftz_decoder #(.CNT_WIDTH(CW)) dut (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_valid     (i_valid),
      .o_ready     (o_ready),
      .i_data      (i_data),
      .o_valid     (o_valid),
      .i_ready     (i_ready),
      .o_sign      (o_sign),
      .o_exponent  (o_exponent),
      .o_mantissa  (o_mantissa),
      .o_type      (o_type),
      .o_ftz_count (o_ftz_count),
      .i_cnt_clear (i_cnt_clear)
   );

   always #5 i_clk = ~i_clk;

   function automatic dec_t ref_decode(input logic [15:0] w);
      dec_t r;
      int   e;
      int   f;
      e   = int'(w[14:10]);
      f   = int'(w[9:0]);
      r.s = w[15];
      r.e = 5'd0;
      r.m = 11'd0;
      r.t = `FP16_ZERO;
      if (e == 31) begin
         r.e = 5'd31;
         r.m = 11'(f);
         r.t = (f == 0) ? `FP16_INF : `FP16_NAN;
      end else if (e > 0) begin
         r.e = 5'(e);
         r.m = 11'(1024 + f);
         r.t = `FP16_NORM;
      end else if (f != 0 && !FTZ) begin
         r.e = 5'd1;
         r.m = 11'(f);
         r.t = `FP16_SUBN;
      end
      return r;
   endfunction

   function automatic bit is_subn(input logic [15:0] w);
      return (w[14:10] == 5'd0) && (w[9:0] != 10'd0);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("o_valid", 32'(o_valid), 32'(q.size() > 0));
      chk("o_ready", 32'(o_ready), 32'(q.size() < 2));
      chk("o_ftz_count", 32'(o_ftz_count), 32'(cnt_m));
      if (q.size() > 0) begin
         chk("o_sign", 32'(o_sign), 32'(q[0].s));
         chk("o_exponent", 32'(o_exponent), 32'(q[0].e));
         chk("o_mantissa", 32'(o_mantissa), 32'(q[0].m));
         chk("o_type", 32'(o_type), 32'(q[0].t));
      end
   endtask

   task automatic step(input logic v, input logic [15:0] d, input logic r, input logic clr);
      bit in_x;
      bit out_x;
      i_valid     = v;
      i_data      = d;
      i_ready     = r;
      i_cnt_clear = clr;
      in_x  = v && (q.size() < 2);
      out_x = r && (q.size() > 0);
      @(posedge i_clk);
      if (out_x) void'(q.pop_front());
      if (in_x) q.push_back(ref_decode(d));
      if (clr) cnt_m = 0;
      else if (in_x && FTZ && is_subn(d) && cnt_m < CMAX) cnt_m++;
      #1;
      check_all();
   endtask

   task automatic do_reset(input logic v, input logic [15:0] d, input logic r);
      i_rst   = 1'b1;
      i_valid = v;
      i_data  = d;
      i_ready = r;
      @(posedge i_clk);
      q.delete();
      cnt_m = 0;
      #1;
      i_rst = 1'b0;
      check_all();
   endtask

   initial begin
      logic [15:0] w;
      logic [9:0]  fr;
      i_rst = 1'b1; i_valid = 1'b0; i_data = '0; i_ready = 1'b0; i_cnt_clear = 1'b0;
      @(negedge i_clk);

      // Reset state
      do_reset(1'b0, 16'h0000, 1'b0);
      chk("rst_type", 32'(o_type), 32'(`FP16_ZERO));
      chk("rst_mant", 32'(o_mantissa), 32'd0);
      chk("rst_exp", 32'(o_exponent), 32'd0);

      // 1.0
      step(1'b1, 16'h3C00, 1'b1, 1'b0);
      chk("one_exp", 32'(o_exponent), 32'd15);
      chk("one_mant", 32'(o_mantissa), 32'h400);
      chk("one_type", 32'(o_type), 32'(`FP16_NORM));
      chk("one_valid", 32'(o_valid), 32'd1);

      // Subnormals
      do_reset(1'b0, 16'h0000, 1'b1);
      step(1'b1, 16'h8001, 1'b1, 1'b0);
      chk("subn1_sign", 32'(o_sign), 32'd1);
      chk("subn1_type", 32'(o_type), FTZ ? 32'(`FP16_ZERO) : 32'(`FP16_SUBN));
      chk("subn1_mant", 32'(o_mantissa), FTZ ? 32'd0 : 32'h001);
      step(1'b1, 16'h03FF, 1'b1, 1'b0);
      chk("subn2_sign", 32'(o_sign), 32'd0);
      chk("subn2_exp", 32'(o_exponent), FTZ ? 32'd0 : 32'd1);
      chk("subn2_mant", 32'(o_mantissa), FTZ ? 32'd0 : 32'h3FF);
      chk("subn_count", 32'(o_ftz_count), FTZ ? 32'd2 : 32'd0);

      // Specials
      step(1'b1, 16'h7C00, 1'b1, 1'b0);
      chk("inf_type", 32'(o_type), 32'(`FP16_INF));
      chk("inf_exp", 32'(o_exponent), 32'd31);
      step(1'b1, 16'hFE00, 1'b1, 1'b0);
      chk("nan_type", 32'(o_type), 32'(`FP16_NAN));
      chk("nan_mant", 32'(o_mantissa), 32'h200);
      chk("nan_sign", 32'(o_sign), 32'd1);
      step(1'b1, 16'h0000, 1'b1, 1'b0);
      chk("zero_type", 32'(o_type), 32'(`FP16_ZERO));
      step(1'b0, 16'h0000, 1'b1, 1'b0);

      // Backpressure: third word must wait, order preserved after release
      do_reset(1'b0, 16'h0000, 1'b0);
      step(1'b1, 16'h3C00, 1'b0, 1'b0);
      step(1'b1, 16'h4000, 1'b0, 1'b0);
      chk("bp_ready_low", 32'(o_ready), 32'd0);
      step(1'b1, 16'h4200, 1'b0, 1'b0);
      step(1'b1, 16'h4200, 1'b0, 1'b0);
      chk("bp_hold_exp", 32'(o_exponent), 32'd15);
      chk("bp_hold_mant", 32'(o_mantissa), 32'h400);
      for (int i = 0; i < 4; i++) step(1'b1, 16'h4200, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, 16'h0000, 1'b1, 1'b0);
      chk("bp_drained", 32'(o_valid), 32'd0);

      // Counter saturation and clear priority
      do_reset(1'b0, 16'h0000, 1'b1);
      for (int i = 0; i < CMAX + 4; i++) step(1'b1, 16'h0001, 1'b1, 1'b0);
      chk("cnt_sat", 32'(o_ftz_count), FTZ ? 32'(CMAX) : 32'd0);
      step(1'b1, 16'h8002, 1'b1, 1'b1);
      chk("cnt_clear", 32'(o_ftz_count), 32'd0);
      step(1'b1, 16'h0005, 1'b1, 1'b0);

      // Reset while both entries are full
      step(1'b1, 16'h0003, 1'b0, 1'b0);
      step(1'b1, 16'h0004, 1'b0, 1'b0);
      chk("full_before_rst", 32'(o_ready), 32'd0);
      do_reset(1'b1, 16'h4400, 1'b0);
      chk("rst_mid_valid", 32'(o_valid), 32'd0);
      chk("rst_mid_ready", 32'(o_ready), 32'd1);
      chk("rst_mid_cnt", 32'(o_ftz_count), 32'd0);
      step(1'b1, 16'hC500, 1'b1, 1'b0);
      chk("post_rst_exp", 32'(o_exponent), 32'd17);
      chk("post_rst_mant", 32'(o_mantissa), 32'h500);
      chk("post_rst_sign", 32'(o_sign), 32'd1);

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         fr = 10'($urandom_range(1, 1023));
         case ($urandom_range(0, 4))
            0: w = {1'($urandom), 5'd0, fr};
            1: w = {1'($urandom), 15'd0};
            2: w = {1'($urandom), 5'd31, ($urandom_range(0, 1) == 0) ? 10'd0 : fr};
            default: w = 16'($urandom);
         endcase
         step(1'($urandom), w, 1'($urandom), ($urandom_range(0, 31) == 0));
      end
      for (int i = 0; i < 3; i++) step(1'b0, 16'h0000, 1'b1, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
